rxframer2: RTL and testbench



---
 rtl/rxframer2.sv | 173 +++++++++++++++++
 tb/tb_rxframer2.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rxframer2.sv
// Receive byte-to-word framer: checks/strips preamble+SFD, packs bytes big-endian into 32-bit words.
// Optional build macro RXFRAMER2_RUNT_CHECK_EN flags frames shorter than 64 bytes as bad.
module rxframer2 #(
  parameter int unsigned MAXBYTES = 1522
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rxdv,
  input  logic [7:0]  rxd,
  input  logic        rxer,
  output logic        validout,
  output logic        sofout,
  output logic        eofout,
  output logic [31:0] dataout,
  output logic [1:0]  lastbytes,
  output logic        frameerr,
  output logic [15:0] framecount
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PREAMBLE = 2'd1;
  localparam logic [1:0] DATA     = 2'd2;
  localparam logic [1:0] DROP     = 2'd3;

  logic [1:0]  state, state_d;
  logic [2:0]  precnt, precnt_d;
  logic [10:0] bytecnt, bytecnt_d, newcnt;
  logic [23:0] acc, acc_d;
  logic [31:0] pendword, pendword_d;
  logic        pending, pending_d;
  logic        sofdone, sofdone_d;
  logic        runt;

  logic        validout_d, sofout_d, eofout_d, frameerr_d;
  logic [31:0] dataout_d;
  logic [1:0]  lastbytes_d;
  logic [15:0] framecount_d;

`ifdef RXFRAMER2_RUNT_CHECK_EN
  assign runt = (bytecnt < 11'd64);
`else
  assign runt = 1'b0;
`endif

  assign newcnt = bytecnt + 11'd1;

  always_comb begin
    state_d      = state;
    precnt_d     = precnt;
    bytecnt_d    = bytecnt;
    acc_d        = acc;
    pendword_d   = pendword;
    pending_d    = pending;
    sofdone_d    = sofdone;
    validout_d   = 1'b0;
    sofout_d     = 1'b0;
    eofout_d     = 1'b0;
    frameerr_d   = 1'b0;
    dataout_d    = 32'd0;
    lastbytes_d  = 2'd0;
    framecount_d = framecount;

    unique case (state)
      IDLE: begin
        if (rxdv) begin
          if (rxd == 8'h55) begin
            state_d  = PREAMBLE;
            precnt_d = 3'd1;
          end else begin
            state_d = DROP;
          end
        end
      end

      PREAMBLE: begin
        if (!rxdv) begin
          state_d = IDLE;
        end else if (rxd == 8'h55) begin
          if (precnt == 3'd7) state_d = DROP;
          else precnt_d = precnt + 3'd1;
        end else if (rxd == 8'hD5) begin
          state_d   = DATA;
          bytecnt_d = 11'd0;
          pending_d = 1'b0;
          sofdone_d = 1'b0;
        end else begin
          state_d = DROP;
        end
      end

      DATA: begin
        if (rxdv && (rxer || (32'(newcnt) == MAXBYTES + 32'd1))) begin
          // Error end: a terminating word is only meaningful if the frame was already opened.
          state_d = DROP;
          if (sofdone) begin
            validout_d = 1'b1;
            eofout_d   = 1'b1;
            frameerr_d = 1'b1;
          end
        end else if (rxdv) begin
          bytecnt_d = newcnt;
          acc_d     = {acc[15:0], rxd};
          pending_d = 1'b0;
          if (pending) begin
            validout_d = 1'b1;
            sofout_d   = !sofdone;
            sofdone_d  = 1'b1;
            dataout_d  = pendword;
          end
          if (bytecnt[1:0] == 2'd3) begin
            pendword_d = {acc, rxd};
            pending_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
          if (bytecnt != 11'd0) begin
            validout_d  = 1'b1;
            eofout_d    = 1'b1;
            sofout_d    = !sofdone;
            lastbytes_d = bytecnt[1:0];
            frameerr_d  = runt;
            unique case (bytecnt[1:0])
              2'd1:    dataout_d = {acc[7:0], 24'd0};
              2'd2:    dataout_d = {acc[15:0], 16'd0};
              2'd3:    dataout_d = {acc[23:0], 8'd0};
              default: dataout_d = pendword;
            endcase
            if (!runt) framecount_d = framecount + 16'd1;
          end
        end
      end

      default: begin
        if (!rxdv) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      precnt     <= 3'd0;
      bytecnt    <= 11'd0;
      acc        <= 24'd0;
      pendword   <= 32'd0;
      pending    <= 1'b0;
      sofdone    <= 1'b0;
      validout   <= 1'b0;
      sofout     <= 1'b0;
      eofout     <= 1'b0;
      frameerr   <= 1'b0;
      dataout    <= 32'd0;
      lastbytes  <= 2'd0;
      framecount <= 16'd0;
    end else begin
      state      <= state_d;
      precnt     <= precnt_d;
      bytecnt    <= bytecnt_d;
      acc        <= acc_d;
      pendword   <= pendword_d;
      pending    <= pending_d;
      sofdone    <= sofdone_d;
      validout   <= validout_d;
      sofout     <= sofout_d;
      eofout     <= eofout_d;
      frameerr   <= frameerr_d;
      dataout    <= dataout_d;
      lastbytes  <= lastbytes_d;
      framecount <= framecount_d;
    end
  end

endmodule

// File: tb/tb_rxframer2.sv
// Directed self-checking bench for rxframer2; output words are captured into a queue and checked per test.
module tb_rxframer2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rxdv = 1'b0;
  logic [7:0]  rxd = 8'd0;
  logic        rxer = 1'b0;
  logic        validout, sofout, eofout, frameerr;
  logic [31:0] dataout;
  logic [1:0]  lastbytes;
  logic [15:0] framecount;

  rxframer2 dut (
    .clock      (clock),
    .reset      (reset),
    .rxdv       (rxdv),
    .rxd        (rxd),
    .rxer       (rxer),
    .validout   (validout),
    .sofout     (sofout),
    .eofout     (eofout),
    .dataout    (dataout),
    .lastbytes  (lastbytes),
    .frameerr   (frameerr),
    .framecount (framecount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic        er;
    logic [1:0]  lb;
    int          c;
  } wrd_t;

  wrd_t        q[$];
  int          cyc = 0;
  int          viol = 0;
  int          nchk = 0;
  int          nfail = 0;
  int          end_cyc, sof_cyc;
  logic [15:0] exp_fc = 16'd0;
  logic [7:0]  pay[0:1599];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (validout) q.push_back('{d: dataout, s: sofout, e: eofout, er: frameerr, lb: lastbytes, c: cyc});
    else if (sofout || eofout || frameerr || (lastbytes != 2'd0)) viol++;
  end

  task automatic drive_byte(input logic dv, input logic [7:0] b, input logic er);
    @(posedge clock);
    #1;
    rxdv = dv;
    rxd  = b;
    rxer = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_byte(1'b0, 8'h00, 1'b0);
  endtask

  // npre x 0x55, optional SFD, len payload bytes with rxer on index errat (-1 none), then rxdv low.
  task automatic send_frame(input int npre, input bit sfd, input int len, input int errat);
    for (int i = 0; i < npre; i++) drive_byte(1'b1, 8'h55, 1'b0);
    if (sfd) drive_byte(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < len; i++) begin
      drive_byte(1'b1, pay[i], (i == errat));
      if (i == 4) sof_cyc = cyc + 1;
    end
    @(posedge clock);
    #1;
    rxdv = 1'b0;
    rxer = 1'b0;
    end_cyc = cyc + 1;
  endtask

  task automatic fill_ramp(input logic [7:0] base);
    for (int i = 0; i < 1600; i++) pay[i] = base + 8'(i);
  endtask

  task automatic test_reset;
    nchk++; if (validout !== 1'b0) begin nfail++; $display("FAIL reset_validout got %b want 0", validout); end
    nchk++; if (sofout !== 1'b0) begin nfail++; $display("FAIL reset_sofout got %b want 0", sofout); end
    nchk++; if (eofout !== 1'b0) begin nfail++; $display("FAIL reset_eofout got %b want 0", eofout); end
    nchk++; if (dataout !== 32'd0) begin nfail++; $display("FAIL reset_dataout got %h want 0", dataout); end
    nchk++; if (lastbytes !== 2'd0) begin nfail++; $display("FAIL reset_lastbytes got %0d want 0", lastbytes); end
    nchk++; if (frameerr !== 1'b0) begin nfail++; $display("FAIL reset_frameerr got %b want 0", frameerr); end
    nchk++; if (framecount !== 16'd0) begin nfail++; $display("FAIL reset_framecount got %0d want 0", framecount); end
  endtask

  task automatic test_frame64;
    logic [31:0] w;
    q.delete();
    fill_ramp(8'h00);
    send_frame(7, 1'b1, 64, -1);
    idle(8);
    exp_fc = exp_fc + 16'd1;
    nchk++; if (q.size() != 16) begin nfail++; $display("FAIL f64_nwords got %0d want 16", q.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        nchk++; if (q[i].d !== w) begin nfail++; $display("FAIL f64_word%0d got %h want %h", i, q[i].d, w); end
        nchk++; if (q[i].s !== (i == 0)) begin nfail++; $display("FAIL f64_sof%0d got %b", i, q[i].s); end
        nchk++; if (q[i].e !== (i == 15)) begin nfail++; $display("FAIL f64_eof%0d got %b", i, q[i].e); end
      end
      nchk++; if (q[15].lb !== 2'd0) begin nfail++; $display("FAIL f64_lastbytes got %0d want 0", q[15].lb); end
      nchk++; if (q[15].er !== 1'b0) begin nfail++; $display("FAIL f64_frameerr got %b want 0", q[15].er); end
      nchk++; if (q[0].c != sof_cyc) begin nfail++; $display("FAIL f64_sof_cycle got %0d want %0d", q[0].c, sof_cyc); end
      nchk++; if (q[15].c != end_cyc) begin nfail++; $display("FAIL f64_eof_cycle got %0d want %0d", q[15].c, end_cyc); end
    end
    nchk++; if (framecount !== exp_fc) begin nfail++; $display("FAIL f64_framecount got %0d want %0d", framecount, exp_fc); end
  endtask

  task automatic test_frame66;
    q.delete();
    fill_ramp(8'h00);
    send_frame(7, 1'b1, 66, -1);
    idle(8);
    exp_fc = exp_fc + 16'd1;
    nchk++; if (q.size() != 17) begin nfail++; $display("FAIL f66_nwords got %0d want 17", q.size()); end
    else begin
      nchk++; if (q[15].d !== 32'h3C3D3E3F || q[15].e !== 1'b0) begin nfail++; $display("FAIL f66_word16 got %h eof %b want 3c3d3e3f eof 0", q[15].d, q[15].e); end
      nchk++; if (q[16].d !== 32'h40410000) begin nfail++; $display("FAIL f66_word17 got %h want 40410000", q[16].d); end
      nchk++; if (q[16].e !== 1'b1 || q[16].s !== 1'b0) begin nfail++; $display("FAIL f66_eof got eof %b sof %b want 1 0", q[16].e, q[16].s); end
      nchk++; if (q[16].lb !== 2'd2) begin nfail++; $display("FAIL f66_lastbytes got %0d want 2", q[16].lb); end
      nchk++; if (q[16].c != end_cyc) begin nfail++; $display("FAIL f66_eof_cycle got %0d want %0d", q[16].c, end_cyc); end
    end
    nchk++; if (framecount !== exp_fc) begin nfail++; $display("FAIL f66_framecount got %0d want %0d", framecount, exp_fc); end
  endtask

  task automatic test_runt;
    logic exp_err;
`ifdef RXFRAMER2_RUNT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    q.delete();
    fill_ramp(8'hA0);
    send_frame(7, 1'b1, 10, -1);
    idle(8);
    if (!exp_err) exp_fc = exp_fc + 16'd1;
    nchk++; if (q.size() != 3) begin nfail++; $display("FAIL runt_nwords got %0d want 3", q.size()); end
    else begin
      nchk++; if (q[0].d !== 32'hA0A1A2A3 || q[0].s !== 1'b1) begin nfail++; $display("FAIL runt_w0 got %h sof %b", q[0].d, q[0].s); end
      nchk++; if (q[1].d !== 32'hA4A5A6A7) begin nfail++; $display("FAIL runt_w1 got %h want a4a5a6a7", q[1].d); end
      nchk++; if (q[2].d !== 32'hA8A90000 || q[2].e !== 1'b1) begin nfail++; $display("FAIL runt_w2 got %h eof %b", q[2].d, q[2].e); end
      nchk++; if (q[2].lb !== 2'd2) begin nfail++; $display("FAIL runt_lastbytes got %0d want 2", q[2].lb); end
      nchk++; if (q[2].er !== exp_err) begin nfail++; $display("FAIL runt_frameerr got %b want %b", q[2].er, exp_err); end
    end
    nchk++; if (framecount !== exp_fc) begin nfail++; $display("FAIL runt_framecount got %0d want %0d", framecount, exp_fc); end
  endtask

  task automatic test_rxer;
    q.delete();
    fill_ramp(8'h00);
    send_frame(7, 1'b1, 100, 19);
    idle(8);
    nchk++; if (q.size() != 5) begin nfail++; $display("FAIL rxer_nwords got %0d want 5", q.size()); end
    else begin
      nchk++; if (q[3].d !== 32'h0C0D0E0F || q[3].e !== 1'b0) begin nfail++; $display("FAIL rxer_w4 got %h eof %b", q[3].d, q[3].e); end
      nchk++; if (q[4].d !== 32'd0 || q[4].e !== 1'b1 || q[4].er !== 1'b1) begin nfail++; $display("FAIL rxer_errword got %h eof %b err %b want 0 1 1", q[4].d, q[4].e, q[4].er); end
      nchk++; if (q[4].lb !== 2'd0) begin nfail++; $display("FAIL rxer_lastbytes got %0d want 0", q[4].lb); end
    end
    nchk++; if (framecount !== exp_fc) begin nfail++; $display("FAIL rxer_framecount got %0d want %0d", framecount, exp_fc); end
  endtask

  task automatic test_oversize_gap;
    q.delete();
    fill_ramp(8'h00);
    send_frame(7, 1'b1, 1600, -1);
    // Exactly one rxdv-low cycle before the next frame.
    send_frame(7, 1'b1, 64, -1);
    idle(8);
    exp_fc = exp_fc + 16'd1;
    nchk++; if (q.size() != 397) begin nfail++; $display("FAIL over_nwords got %0d want 397", q.size()); end
    else begin
      nchk++; if (q[379].d !== 32'hECEDEEEF || q[379].e !== 1'b0) begin nfail++; $display("FAIL over_lastdata got %h eof %b", q[379].d, q[379].e); end
      nchk++; if (q[380].d !== 32'd0 || q[380].e !== 1'b1 || q[380].er !== 1'b1) begin nfail++; $display("FAIL over_errword got %h eof %b err %b", q[380].d, q[380].e, q[380].er); end
      nchk++; if (q[381].d !== 32'h00010203 || q[381].s !== 1'b1) begin nfail++; $display("FAIL gap_first got %h sof %b", q[381].d, q[381].s); end
      nchk++; if (q[396].d !== 32'h3C3D3E3F || q[396].e !== 1'b1 || q[396].er !== 1'b0) begin nfail++; $display("FAIL gap_last got %h eof %b err %b", q[396].d, q[396].e, q[396].er); end
    end
    nchk++; if (framecount !== exp_fc) begin nfail++; $display("FAIL over_framecount got %0d want %0d", framecount, exp_fc); end
  endtask

  task automatic test_bad_preamble;
    fill_ramp(8'h10);
    q.delete();
    send_frame(0, 1'b1, 20, -1);
    idle(4);
    nchk++; if (q.size() != 0) begin nfail++; $display("FAIL bad_nopre got %0d words want 0", q.size()); end
    q.delete();
    send_frame(8, 1'b1, 20, -1);
    idle(4);
    nchk++; if (q.size() != 0) begin nfail++; $display("FAIL bad_8x55 got %0d words want 0", q.size()); end
    q.delete();
    pay[0] = 8'h12;
    send_frame(1, 1'b0, 20, -1);
    idle(4);
    nchk++; if (q.size() != 0) begin nfail++; $display("FAIL bad_55_12 got %0d words want 0", q.size()); end
    nchk++; if (framecount !== exp_fc) begin nfail++; $display("FAIL bad_framecount got %0d want %0d", framecount, exp_fc); end
    // Reset inside DATA, released while the PHY keeps streaming.
    q.delete();
    for (int i = 0; i < 7; i++) drive_byte(1'b1, 8'h55, 1'b0);
    drive_byte(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 3; i++) drive_byte(1'b1, 8'h20 + 8'(i), 1'b0);
    reset = 1'b1;
    drive_byte(1'b1, 8'h23, 1'b0);
    drive_byte(1'b1, 8'h24, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) drive_byte(1'b1, 8'h25 + 8'(i), 1'b0);
    idle(6);
    exp_fc = 16'd0;
    nchk++; if (q.size() != 0) begin nfail++; $display("FAIL bad_reset_mid got %0d words want 0", q.size()); end
    nchk++; if (framecount !== exp_fc) begin nfail++; $display("FAIL bad_reset_framecount got %0d want 0", framecount); end
  endtask

  task automatic test_quiet_outputs;
    nchk++; if (viol != 0) begin nfail++; $display("FAIL quiet_flags got %0d violations want 0", viol); end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    test_reset;
    reset = 1'b0;
    idle(2);
    test_reset;
    test_frame64;
    test_frame66;
    test_runt;
    test_rxer;
    test_oversize_gap;
    test_bad_preamble;
    test_quiet_outputs;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
